peak_gen_nbit: RTL
==================

Name: peak_gen_nbit

Overview:
- Pulse-train ("peak") generator: on command, emits a programmable number of rectangular pulses on a single-bit output, with programmable high and low times.
- It is the stimulus source for the peak counter path. sig_out drives a counter's sig_in, and the clken gating matches on both ends, so every emitted pulse is seen as exactly one rising edge.
- Used for self-test and calibration of the counter chain, from the host-side control registers.

Parameters:
- CNTR_WIDTH, 8, width of the pulse-count request and the sent-pulse count.
- PER_WIDTH, 8, width of the high-time and low-time fields, in clken ticks.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset); deassertion externally synchronised to clk.
- clken  input  1  tick enable; all timing and state advance only on cycles with clken=1.
- start  input  1  request a pulse train; sampled only in IDLE on a clken cycle.
- num_pulses  input  CNTR_WIDTH  number of pulses to emit; latched at start.
- high_cycles  input  PER_WIDTH  pulse high time in ticks; latched at start; 0 treated as 1.
- low_cycles  input  PER_WIDTH  gap low time in ticks; latched at start; 0 treated as 1.
- sig_out  output  1  registered pulse output.
- busy  output  1  high while in HIGH or LOW state.
- done  output  1  one-clk pulse when a train completes.
- sent_count  output  CNTR_WIDTH  pulses emitted in the current or most recent train.

Behaviour:
- Reset (rst=0, asynchronous), applies in any state including mid-train:
  - sig_out=0, busy=0, done=0, sent_count=0.
  - State=IDLE; internal counters and latched fields cleared.
- States and transitions (all transitions and counter updates require clken=1):
  - IDLE:
    - start=1 and num_pulses!=0: latch num_pulses, max(high_cycles,1) and max(low_cycles,1); clear sent_count; go to HIGH.
    - start=1 and num_pulses=0: go to DONE; sent_count cleared; sig_out stays 0.
  - HIGH:
    - sig_out=1.
    - On entry, sent_count increments (saturating is not needed; latched N ≤ 2^CNTR_WIDTH-1).
    - Stay H ticks, then go to LOW.
  - LOW:
    - sig_out=0.
    - Stay L ticks.
    - Then: if sent_count==N, go to DONE; else go to HIGH.
    - The trailing low phase is always emitted, so the line idles low for at least L ticks before done.
  - DONE:
    - done=1, busy=0, sig_out=0.
    - Held for exactly one clk cycle regardless of clken; then IDLE.
- Output timing:
  - sig_out, busy and done are registered.
  - Start accepted on the clk edge of cycle t (clken=1) gives sig_out=1 and busy=1 from cycle t+1.
  - With clken held high, each period is H+L clk cycles and done occurs at t+1+N*(H+L).
- clken=0 mid-train: all outputs and counters freeze (waveform stretched, not corrupted).
- start while busy or in DONE: ignored; no queuing.
- Input changes during a train: num_pulses, high_cycles and low_cycles have no effect until the next accepted start.
- Max values: N=2^CNTR_WIDTH-1, H=L=2^PER_WIDTH-1 supported without wrap. Phase counters are PER_WIDTH bits and count down from the latched value to 1.
- sent_count: holds its final value after DONE until the next accepted start or reset.

Optional Feature:
- Macro: PEAK_GEN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in HIGH or LOW, on any clk (not gated by clken): next cycle sig_out=0, busy=0, done=1 for one cycle, state=IDLE.
  - sent_count keeps the number of pulses emitted so far.
  - abort in IDLE or DONE has no effect.
  - If start and abort are high in the same IDLE cycle, start wins.
- Not defined: no abort port; a train always runs to completion or reset.

Test Plan:
- Basic train: rst released, clken=1, start at cycle 0 with N=3, H=2, L=1.
  - Response: sig_out over cycles 1..9 = 1,1,0,1,1,0,1,1,0.
  - done=1 only at cycle 10; busy=1 cycles 1..9; sent_count=3.
- Zero fields: N=0.
  - Response: sig_out never rises; done=1 one cycle after start; sent_count=0.
- Zero times: N=2, H=0, L=0.
  - Response: behaves as H=L=1, giving sig_out 1,0,1,0, then done.
- clken gating: clken asserted every 4th clk, N=2, H=1, L=1.
  - Response: each sig_out level lasts 4 clks.
  - Loopback into an 8-bit peak counter with the same clken reads count_out=2 and overflow clear.
- Start while busy and reset mid-train: during N=5 train, pulse start again, then assert rst after pulse 2.
  - Response: the second start has no effect.
  - On rst assertion, outputs go to 0 asynchronously, without waiting for a clk edge.
  - After release, a new start with N=1 works normally.
- Abort (PEAK_GEN_ABORT_EN defined): N=200, H=1, L=1; abort during the 4th high phase.
  - Response: next cycle sig_out=0, done=1, sent_count=4, busy=0.

Source files
------------

// File: rtl/peak_gen_nbit_if.sv
// Control/status bundle between a host and the peak_gen_nbit pulse-train generator.
// The abort signal exists only when PEAK_GEN_ABORT_EN is defined.
interface peak_gen_nbit_if #(
    parameter int CNTR_WIDTH = 8,
    parameter int PER_WIDTH  = 8
);
    logic                  start;
    logic [CNTR_WIDTH-1:0] num_pulses;
    logic [PER_WIDTH-1:0]  high_cycles;
    logic [PER_WIDTH-1:0]  low_cycles;
`ifdef PEAK_GEN_ABORT_EN
    logic                  abort;
`endif
    logic                  sig_out;
    logic                  busy;
    logic                  done;
    logic [CNTR_WIDTH-1:0] sent_count;

    modport master (
        output start, num_pulses, high_cycles, low_cycles,
`ifdef PEAK_GEN_ABORT_EN
        output abort,
`endif
        input  sig_out, busy, done, sent_count
    );

    modport slave (
        input  start, num_pulses, high_cycles, low_cycles,
`ifdef PEAK_GEN_ABORT_EN
        input  abort,
`endif
        output sig_out, busy, done, sent_count
    );
endinterface

// File: rtl/peak_gen_nbit.sv
// peak_gen_nbit: emits N rectangular pulses of H high / L low clken ticks on command.
// Define PEAK_GEN_ABORT_EN to add an abort input that ends a train early.
module peak_gen_nbit #(
    parameter int CNTR_WIDTH = 8,
    parameter int PER_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clken,
    peak_gen_nbit_if.slave bus
);
    localparam logic [PER_WIDTH-1:0]  PER_ONE  = PER_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    state_t                state, state_nx;
    logic [CNTR_WIDTH-1:0] n_lat, n_lat_nx;
    logic [CNTR_WIDTH-1:0] sent, sent_nx;
    logic [PER_WIDTH-1:0]  h_lat, h_lat_nx;
    logic [PER_WIDTH-1:0]  l_lat, l_lat_nx;
    logic [PER_WIDTH-1:0]  phase, phase_nx;
    logic                  sig_q, busy_q, done_q;
    logic                  abort_hit;

    // A zero phase length would stall the train, so it is promoted to one tick.
    function automatic logic [PER_WIDTH-1:0] floor_one(input logic [PER_WIDTH-1:0] v);
        return (v == '0) ? PER_ONE : v;
    endfunction

`ifdef PEAK_GEN_ABORT_EN
    assign abort_hit = bus.abort && ((state == S_HIGH) || (state == S_LOW));
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        n_lat_nx = n_lat;
        h_lat_nx = h_lat;
        l_lat_nx = l_lat;
        phase_nx = phase;
        sent_nx  = sent;
        if (abort_hit) begin
            state_nx = S_DONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clken && bus.start) begin
                        if (bus.num_pulses != '0) begin
                            n_lat_nx = bus.num_pulses;
                            h_lat_nx = floor_one(bus.high_cycles);
                            l_lat_nx = floor_one(bus.low_cycles);
                            phase_nx = floor_one(bus.high_cycles);
                            sent_nx  = CNTR_ONE;
                            state_nx = S_HIGH;
                        end else begin
                            sent_nx  = '0;
                            state_nx = S_DONE;
                        end
                    end
                end
                S_HIGH: begin
                    if (clken) begin
                        if (phase <= PER_ONE) begin
                            phase_nx = l_lat;
                            state_nx = S_LOW;
                        end else begin
                            phase_nx = phase - PER_ONE;
                        end
                    end
                end
                S_LOW: begin
                    if (clken) begin
                        if (phase <= PER_ONE) begin
                            if (sent == n_lat) begin
                                state_nx = S_DONE;
                            end else begin
                                phase_nx = h_lat;
                                sent_nx  = sent + CNTR_ONE;
                                state_nx = S_HIGH;
                            end
                        end else begin
                            phase_nx = phase - PER_ONE;
                        end
                    end
                end
                // DONE is a single clk regardless of clken so done is always one cycle wide.
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            n_lat  <= '0;
            h_lat  <= '0;
            l_lat  <= '0;
            phase  <= '0;
            sent   <= '0;
            sig_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            n_lat  <= n_lat_nx;
            h_lat  <= h_lat_nx;
            l_lat  <= l_lat_nx;
            phase  <= phase_nx;
            sent   <= sent_nx;
            sig_q  <= (state_nx == S_HIGH);
            busy_q <= (state_nx == S_HIGH) || (state_nx == S_LOW);
            done_q <= (state_nx == S_DONE);
        end
    end

    assign bus.sig_out    = sig_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sent_count = sent;
endmodule
